conc_stim_sequencer: RTL and testbench

- Synthesizable stimulus sequencer and response compactor for the b01 serial-line benchmark.
- Holds a small opcode program and replays it onto the DUT inputs, one opcode per clock. Drives `line1`, `line2` and `obs`.
- Compacts the DUT `outp`/`overflw` responses into a 16-bit MISR signature plus an overflow counter.
- Sits between a host/config interface and the b01 instance, replacing a free-running program counter with a start/busy/done controller.

---
 rtl/conc_pkg.sv | 30 +++
 rtl/conc_stim_sequencer_if.sv | 39 +++
 rtl/conc_misr16.sv | 41 ++++
 rtl/conc_stim_sequencer.sv | 168 ++++++++++++++++
 tb/tb_conc_stim_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conc_pkg.sv
// Shared definitions for the b01 stimulus sequencer / response compactor.
//   state_e     : sequencer FSM states
//   MISR_POLY   : feedback polynomial of the 16-bit response signature
//   OP_*        : bit positions of the stimulus fields inside an opcode word
//   OVF_MAX     : saturation value of the overflow counter
//   misr_next() : one signature update step
package conc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    localparam int OP_LINE1 = 0;
    localparam int OP_LINE2 = 1;
    localparam int OP_OBS   = 2;

    localparam logic [7:0] OVF_MAX = 8'd255;

    // Shift left, fold the MSB back through the polynomial, then mix in the
    // two response bits at the bottom.
    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [1:0] din);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {14'b0, din};
    endfunction

endpackage

// File: rtl/conc_stim_sequencer_if.sv
// Host / DUT-facing signal bundle of conc_stim_sequencer.
//   master : environment side (host config + b01 responses), drives requests
//   slave  : the sequencer, drives stimulus, status and signature
interface conc_stim_sequencer_if #(
    parameter int AW = 6
);
    // host configuration and control
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [2:0]    cfg_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    // status
    logic          busy;
    logic          done;
    logic [AW:0]   pc_out;
    // b01 stimulus and responses
    logic          line1;
    logic          line2;
    logic          obs;
    logic          dut_outp;
    logic          dut_overflw;
    // compacted result
    logic [15:0]   sig;
    logic [7:0]    ovf_count;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, prog_len, start, abort,
        output dut_outp, dut_overflw,
        input  busy, done, pc_out, line1, line2, obs, sig, ovf_count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, prog_len, start, abort,
        input  dut_outp, dut_overflw,
        output busy, done, pc_out, line1, line2, obs, sig, ovf_count
    );
endinterface

// File: rtl/conc_misr16.sv
// 16-bit multiple-input signature register.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears the signature
//   clr   : synchronous clear (wins over en)
//   en    : absorb din on this edge
//   din   : {overflw, outp} response bits
//   sig   : current signature
module conc_misr16
    import conc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_next(sig_q, din);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/conc_stim_sequencer.sv
// Stimulus sequencer and response compactor for the b01 benchmark.
// Replays a host-loaded opcode program onto line1/line2/obs, one opcode per
// clock, and folds the delayed b01 responses into a MISR signature plus a
// saturating overflow counter.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : cfg_we/cfg_addr/cfg_wdata program writes, prog_len,
//                  start/abort control, busy/done/pc_out status,
//                  line1/line2/obs stimulus, dut_outp/dut_overflw responses,
//                  sig/ovf_count results
module conc_stim_sequencer
    import conc_pkg::*;
#(
    parameter int AW       = 6,
    parameter int DEPTH    = 2**AW,
    parameter int RESP_LAT = 2      // 1..7
) (
    input  logic                 clock,
    input  logic                 reset,
    conc_stim_sequencer_if.slave bus
);

    localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W      = (AW+1)'(1);
    localparam logic [2:0]  DRAIN_INIT = 3'(RESP_LAT);

    state_e              state_q, state_d;
    logic [AW:0]         pc_q, pc_d;
    logic [AW:0]         len_q, len_d;
    logic [2:0]          drain_q, drain_d;
    logic [2:0]          stim_q, stim_d;
    logic [RESP_LAT-1:0] cap_q, cap_d;
    logic [RESP_LAT-1:0] cap_shift;
    logic [7:0]          ovf_q, ovf_d;

    logic                cap_push;
    logic                cap_flush;
    logic                run_clr;
    logic                cap_en;
    logic [AW:0]         len_clamped;
    logic                mem_we;

    // Program storage; deliberately not reset.
    logic [2:0]          mem [DEPTH];

    assign len_clamped = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;

    // Host writes only land while no run is in flight.
    assign mem_we = bus.cfg_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Capture pipeline: a 1 marks an edge whose response belongs to a
    // launched opcode; the tail lines up with the b01 response latency.
    assign cap_shift[0] = cap_push;
    for (genvar gi = 1; gi < RESP_LAT; gi++) begin : g_cap
        assign cap_shift[gi] = cap_q[gi-1];
    end

    assign cap_en = cap_q[RESP_LAT-1];

    // Sequencer next-state and datapath.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        drain_d   = drain_q;
        stim_d    = '0;
        cap_push  = 1'b0;
        cap_flush = 1'b0;
        run_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_d   = len_clamped;
                    pc_d    = '0;
                    run_clr = 1'b1;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    cap_flush = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stim_d   = mem[pc_q[AW-1:0]];
                    pc_d     = pc_q + ONE_W;
                    cap_push = 1'b1;
                    if (pc_q == len_q - ONE_W) begin
                        drain_d = DRAIN_INIT;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.abort) begin
                    cap_flush = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    drain_d = drain_q - 3'd1;
                    if (drain_q == 3'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cap_d = cap_flush ? '0 : cap_shift;
    end

    // Overflow counter: cleared on an accepted start, saturates at OVF_MAX.
    always_comb begin
        ovf_d = ovf_q;
        if (run_clr) begin
            ovf_d = '0;
        end else if (cap_en && bus.dut_overflw && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            drain_q <= '0;
            stim_q  <= '0;
            cap_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            stim_q  <= stim_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
        end
    end

    conc_misr16 u_misr (
        .clock (clock),
        .reset (reset),
        .clr   (run_clr),
        .en    (cap_en),
        .din   ({bus.dut_overflw, bus.dut_outp}),
        .sig   (bus.sig)
    );

    assign bus.line1     = stim_q[OP_LINE1];
    assign bus.line2     = stim_q[OP_LINE2];
    assign bus.obs       = stim_q[OP_OBS];
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.ovf_count = ovf_q;
    assign bus.pc_out    = pc_q;

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Self-checking bench for conc_stim_sequencer with a per-cycle scoreboard.
module tb_conc_stim_sequencer;

    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int RL    = 2;

    logic clock;
    logic reset;

    conc_stim_sequencer_if #(.AW(AW)) bus ();

    conc_stim_sequencer #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .RESP_LAT (RL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] stim;   // {obs, line2, line1}
    } cyc_t;

    typedef struct packed {
        logic [15:0] sig;
        logic [7:0]  ovf;
        logic [6:0]  pc;
    } res_t;

    cyc_t sb_cyc[$];
    res_t sb_res[$];

    logic [2:0] mem_model [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic ovf, input logic outp);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, ovf, outp};
    endfunction

    function automatic logic [2:0] stim_now();
        return {bus.obs, bus.line2, bus.line1};
    endfunction

    task automatic write_mem(input int addr, input logic [2:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 6'(addr);
        bus.cfg_wdata = data;
        @(posedge clock); #1;
        bus.cfg_we    = 1'b0;
        mem_model[addr] = data;
    endtask

    // Launch a run and compare every following cycle against the scoreboard.
    // pat[c] is the outp value presented for the c-th capture.
    task automatic run_and_check(input int len_in, input logic [63:0] pat, input logic ovf_val);
        int n;
        int last;
        int c;
        int k;
        int ov;
        logic [15:0] s;
        cyc_t e;
        res_t r;
        n    = (len_in > DEPTH) ? DEPTH : len_in;
        last = (n == 0) ? 1 : n + RL + 1;
        for (int i = 0; i <= last; i++) begin
            e.busy = (n > 0) && (i <= n + RL - 1);
            e.done = (n > 0) ? (i == n + RL) : (i == 0);
            e.stim = (i >= 1 && i <= n) ? mem_model[i-1] : 3'b000;
            sb_cyc.push_back(e);
        end
        s  = '0;
        ov = 0;
        for (int i = 0; i < n; i++) begin
            c = i;
            s = misr_step(s, ovf_val, pat[c[5:0]]);
            if (ovf_val && ov < 255) ov++;
        end
        r.sig = s;
        r.ovf = 8'(ov);
        r.pc  = 7'(n);
        sb_res.push_back(r);

        bus.dut_overflw = ovf_val;
        bus.dut_outp    = 1'b0;
        bus.prog_len    = 7'(len_in);
        bus.start       = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        k = 0;
        while (sb_cyc.size() > 0) begin
            e = sb_cyc.pop_front();
            check("busy", 32'(bus.busy), 32'(e.busy));
            check("done", 32'(bus.done), 32'(e.done));
            check("stim", 32'(stim_now()), 32'(e.stim));
            if (e.done) begin
                r = sb_res.pop_front();
                check("sig", 32'(bus.sig), 32'(r.sig));
                check("ovf_count", 32'(bus.ovf_count), 32'(r.ovf));
                check("pc_out", 32'(bus.pc_out), 32'(r.pc));
                $display("run len=%0d sig=%h ovf=%0d pc=%0d", len_in, bus.sig, bus.ovf_count, bus.pc_out);
            end
            c = k - RL;
            bus.dut_outp = (c >= 0 && c < n) ? pat[c[5:0]] : 1'b0;
            @(posedge clock); #1;
            k++;
        end
        bus.dut_overflw = 1'b0;
        bus.dut_outp    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_wdata   = '0;
        bus.prog_len    = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.dut_outp    = 1'b0;
        bus.dut_overflw = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_stim", 32'(stim_now()), 32'd0);
        check("rst_sig", 32'(bus.sig), 32'd0);
        check("rst_ovf", 32'(bus.ovf_count), 32'd0);
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Program: directed head, random tail
        write_mem(0, 3'b001);
        write_mem(1, 3'b010);
        write_mem(2, 3'b100);
        for (int a = 3; a < DEPTH; a++) write_mem(a, 3'($urandom_range(0, 7)));

        // Basic replay and single-capture signature
        run_and_check(3, 64'h0, 1'b0);
        run_and_check(3, 64'h1, 1'b0);
        check("t2_sig_const", 32'(bus.sig), 32'h0004);
        check("t2_ovf_const", 32'(bus.ovf_count), 32'd0);

        // Assorted lengths and response patterns
        run_and_check(7, {$urandom, $urandom}, 1'b0);
        run_and_check(10, {$urandom, $urandom}, 1'b1);

        // Full depth with overflow tied high, then an over-long request
        run_and_check(64, {$urandom, $urandom}, 1'b1);
        check("t3_ovf64_a", 32'(bus.ovf_count), 32'd64);
        run_and_check(100, {$urandom, $urandom}, 1'b1);
        check("t3_ovf64_b", 32'(bus.ovf_count), 32'd64);

        // Empty program
        run_and_check(0, 64'h0, 1'b0);
        check("t6_sig_zero", 32'(bus.sig), 32'd0);

        // abort wins over start in IDLE
        bus.prog_len = 7'd4;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        @(posedge clock); #1;
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_abort_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(posedge clock); #1;

        // Abort mid-run with a write attempted while busy
        bus.prog_len = 7'd5;
        bus.start    = 1'b1;
        @(posedge clock); #1;                 // E0
        bus.start = 1'b0;
        @(posedge clock); #1;                 // after E1
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 6'd0;
        bus.cfg_wdata = ~mem_model[0];
        @(posedge clock); #1;                 // after E2
        bus.cfg_we = 1'b0;
        bus.abort  = 1'b1;
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        @(posedge clock); #1;                 // after E3
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_stim", 32'(stim_now()), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_and_check(5, {$urandom, $urandom}, 1'b0);

        // Asynchronous reset in the middle of a run
        bus.dut_outp = 1'b1;
        bus.prog_len = 7'd5;
        bus.start    = 1'b1;
        @(posedge clock); #1;                 // E0
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;                                   // after E4
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_pc", 32'(bus.pc_out), 32'd4);
        check("pre_rst_sig", 32'(bus.sig), 32'h0003);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_stim", 32'(stim_now()), 32'd0);
        check("arst_sig", 32'(bus.sig), 32'd0);
        check("arst_pc", 32'(bus.pc_out), 32'd0);
        check("arst_ovf", 32'(bus.ovf_count), 32'd0);
        @(posedge clock); #1;
        reset        = 1'b1;
        bus.dut_outp = 1'b0;
        @(posedge clock); #1;
        run_and_check(5, {$urandom, $urandom}, 1'b1);

        // Write accepted in IDLE, then replayed
        write_mem(1, ~mem_model[1]);
        run_and_check(5, {$urandom, $urandom}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
